control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Parametrised next-generation instruction-cycle controller for the accumulator CPU. It keeps the 8-phase fetch/execute sequence and produces the same nine control strobes.
- Adds:
  - a memory-ready stall handshake with a bus timeout,
  - a latched halt state with restart,
  - single-step mode,
  - a generic opcode width with illegal-opcode detection.
- Sits between the instruction register and the datapath/memory interface.

Parameters:
- OPW, 3, opcode width (>=3). Only codes 0..7 are legal.
- MAX_WAIT, 15, maximum stall cycles per memory phase before timeout (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPW  instruction register opcode field.
- zero  in  1  accumulator-zero flag.
- mem_rdy  in  1  memory ready; 1 = access completes this cycle.
- go  in  1  restart request from HALTED.
- step  in  1  single-step mode enable.
- rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel  out  1 each  datapath/memory strobes.
- phase  out  3  current phase 0..7; 0 while HALTED.
- halted  out  1  1 while in HALTED.
- bus_err  out  1  sticky timeout flag.
- ill_op  out  1  sticky illegal-opcode flag.

Behaviour:
- States: P0 INST_ADDR, P1 INST_FETCH, P2 INST_LOAD, P3 IDLE, P4 OP_ADDR, P5 OP_FETCH, P6 ALU_OP, P7 STORE, HALTED.
- All strobes are a Moore decode of the registered state plus the current opcode/zero. The state register is the only sequential control.
- Reset (rst=0, asynchronous):
  - state=P0, wait counter=0, bus_err=0, ill_op=0.
  - Resulting outputs: sel=1, all other strobes 0, phase=0, halted=0.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. ALUOP = ADD|AND|XOR|LDA. Codes >=8 are ILL.
- Strobe decode per state:
  - P0: sel.
  - P1: sel, rd.
  - P2: sel, rd, ld_ir.
  - P3: sel, rd, ld_ir.
  - P4: inc_pc; halt if HLT.
  - P5: rd if ALUOP.
  - P6: rd if ALUOP; inc_pc if SKZ&zero; ld_pc if JMP; data_e if STO.
  - P7: rd if ALUOP; ld_acc if ALUOP; ld_pc if JMP; inc_pc if JMP; data_e if STO; wr if STO.
  - HALTED: halt=1, all other strobes 0.
- ILL opcode: behaves as NOP (only inc_pc in P4). At the P4 edge it sets ill_op=1; ill_op is cleared only by reset.
- Normal advance is one phase per clock, P0->P1->...->P7.
- Stall points are P1, plus P5 when ALUOP, plus P7 when STO:
  - If mem_rdy=0, the state holds, strobes are held unchanged, and the wait counter increments.
  - If mem_rdy=1, the state advances and the counter clears.
  - When the counter reaches MAX_WAIT with mem_rdy still 0: advance anyway, set bus_err=1 (sticky until reset), counter clears.
  - mem_rdy is ignored in all other states.
- P4 with HLT: the next state is HALTED. inc_pc is asserted in P4, so PC already points past HLT.
- P7 exit:
  - If step=1: next state is HALTED.
  - Otherwise: next state is P0.
- HALTED:
  - Holds until go=1 is sampled on a rising edge, then goes to P0.
  - go is ignored in every other state.
  - If step and go are both high while in HALTED, exactly one instruction executes, then HALTED again.
- opcode must be stable from P4 through P7. The decode uses the live value; the block does not latch opcode.
- Reset asserted mid-instruction or mid-stall returns to P0 immediately; no strobe pulse is generated on release.

Test Plan:
- Reset then ADD (opcode=2), mem_rdy=1 -> phases 0..7 in 8 clocks.
  - P5: rd=1. P7: {rd,ld_acc}=1, wr=0. Next cycle P0, sel=1.
- STO (6) with mem_rdy=0 for 3 cycles in P7 -> wr=1 and data_e=1 held for 4 clocks, phase=7 throughout, bus_err=0, then P0.
- LDA (5) with MAX_WAIT=15 and mem_rdy stuck 0 in P5 -> after 15 stalled cycles the state advances to P6 and bus_err=1. bus_err stays 1 through the next two instructions.
- HLT (0) -> P4: halt=1, inc_pc=1. Next clock: halted=1, phase=0, halt=1, sel=0.
  - go held 0 for 10 clocks -> no change.
  - go=1 -> P0 next clock.
- SKZ (1) with zero=1, then zero=0 -> inc_pc=1 in both P4 and P6 for the first; inc_pc in P4 only for the second. JMP (7): ld_pc=1 in P6 and P7.
- OPW=4, opcode=4'hA, step=1 -> P4: inc_pc=1, halt=0, ill_op=1. P5-P7: no rd/wr. After P7 -> HALTED.
  - go pulse -> exactly one more instruction, then HALTED again.
  - Assert rst=0 mid-P5 -> immediate P0, ill_op=0.

Source files
------------

// File: rtl/control_seq.sv
// Instruction-cycle controller for the accumulator CPU: 8-phase fetch/execute
// sequence with memory-ready stalls, bus timeout, latched halt, single-step
// mode and illegal-opcode detection. Strobes are a Moore decode of the state
// register combined with the live opcode/zero inputs.
module control_seq #(
  parameter int OPW      = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  input  logic           go,
  input  logic           step,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_acc,
  output logic           ld_pc,
  output logic           inc_pc,
  output logic           halt,
  output logic           data_e,
  output logic           sel,
  output logic [2:0]     phase,
  output logic           halted,
  output logic           bus_err,
  output logic           ill_op
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_P0     = 4'd0,
    S_P1     = 4'd1,
    S_P2     = 4'd2,
    S_P3     = 4'd3,
    S_P4     = 4'd4,
    S_P5     = 4'd5,
    S_P6     = 4'd6,
    S_P7     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            bus_err_q, bus_err_d;
  logic            ill_op_q, ill_op_d;

  // Opcode classification; any code above 7 is illegal and acts as a NOP.
  logic [2:0] op3_s;
  logic       ill_s, hlt_s, skz_s, alu_s, sto_s, jmp_s;
  logic       stall_pt_s, adv_s;

  assign op3_s = opcode[2:0];
  assign ill_s = |(opcode >> 3);
  assign hlt_s = !ill_s && (op3_s == 3'd0);
  assign skz_s = !ill_s && (op3_s == 3'd1);
  assign alu_s = !ill_s && (op3_s >= 3'd2) && (op3_s <= 3'd5);
  assign sto_s = !ill_s && (op3_s == 3'd6);
  assign jmp_s = !ill_s && (op3_s == 3'd7);

  // Memory phases that wait on mem_rdy for the current instruction.
  assign stall_pt_s = (state_q == S_P1) ||
                      ((state_q == S_P5) && alu_s) ||
                      ((state_q == S_P7) && sto_s);

  // State, wait counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_P0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      ill_op_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      ill_op_q  <= ill_op_d;
    end
  end

  // Stall/timeout handling and next-state selection.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    bus_err_d = bus_err_q;
    ill_op_d  = ill_op_q;
    adv_s     = 1'b1;
    if (stall_pt_s && !mem_rdy) begin
      if (wait_q == WW'(MAX_WAIT)) begin
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WW'(1);
        adv_s  = 1'b0;
      end
    end else begin
      wait_d = '0;
    end
    if (adv_s) begin
      case (state_q)
        S_P0: state_d = S_P1;
        S_P1: state_d = S_P2;
        S_P2: state_d = S_P3;
        S_P3: state_d = S_P4;
        S_P4: begin
          ill_op_d = ill_op_q | ill_s;
          state_d  = hlt_s ? S_HALTED : S_P5;
        end
        S_P5: state_d = S_P6;
        S_P6: state_d = S_P7;
        S_P7: state_d = step ? S_HALTED : S_P0;
        S_HALTED: state_d = go ? S_P0 : S_HALTED;
        default: state_d = S_P0;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Moore strobe decode from the registered state and live opcode/zero.
  always_comb begin
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_acc = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    sel    = 1'b0;
    case (state_q)
      S_P0: sel = 1'b1;
      S_P1: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_P2, S_P3: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_P4: begin
        inc_pc = 1'b1;
        halt   = hlt_s;
      end
      S_P5: rd = alu_s;
      S_P6: begin
        rd     = alu_s;
        inc_pc = skz_s && zero;
        ld_pc  = jmp_s;
        data_e = sto_s;
      end
      S_P7: begin
        rd     = alu_s;
        ld_acc = alu_s;
        ld_pc  = jmp_s;
        inc_pc = jmp_s;
        data_e = sto_s;
        wr     = sto_s;
      end
      S_HALTED: halt = 1'b1;
      default: sel = 1'b0;
    endcase
  end

  assign phase   = (state_q == S_HALTED) ? 3'd0 : state_q[2:0];
  assign halted  = (state_q == S_HALTED);
  assign bus_err = bus_err_q;
  assign ill_op  = ill_op_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: the driver applies randomized and directed
// stimulus, advances an instruction-level reference model and queues the
// expected outputs; a monitor pops and compares on every falling edge.
module tb_control_seq;

  localparam int OPW      = 4;
  localparam int MAX_WAIT = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [OPW-1:0] opcode;
  logic           zero, mem_rdy, go, step;
  logic           rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel;
  logic [2:0]     phase;
  logic           halted, bus_err, ill_op;

  control_seq #(.OPW(OPW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
    .go(go), .step(step), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_acc(ld_acc),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .sel(sel),
    .phase(phase), .halted(halted), .bus_err(bus_err), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, halted flag, stall count, sticky flags.
  int  m_ph;
  bit  m_halted;
  int  m_stalls;
  bit  m_berr, m_ill;

  int  vectors = 0;
  int  errors  = 0;
  logic [14:0] exp_q[$];

  // Stimulus knobs.
  logic [OPW-1:0] want_op;
  bit  want_z, want_go, want_step, rnd_mr;
  int  stall_phase, stall_len;

  function automatic bit is_alu(input logic [OPW-1:0] op);
    return (op >= 4'd2) && (op <= 4'd5);
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_halted = 0; m_stalls = 0; m_berr = 0; m_ill = 0;
  endfunction

  // Advance the model by one rising edge using the inputs that were applied.
  function automatic void model_edge();
    bit waitpt;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_halted) begin
      if (go) begin m_halted = 0; m_ph = 0; end
      return;
    end
    waitpt = (m_ph == 1) || (m_ph == 5 && is_alu(opcode)) || (m_ph == 7 && opcode == 4'd6);
    if (waitpt && !mem_rdy) begin
      if (m_stalls == MAX_WAIT) begin
        m_berr = 1; m_stalls = 0;
      end else begin
        m_stalls++;
        return;
      end
    end else begin
      m_stalls = 0;
    end
    if (m_ph == 4 && opcode >= 4'd8) m_ill = 1;
    if (m_ph == 4 && opcode == 4'd0) begin
      m_halted = 1; m_ph = 0;
    end else if (m_ph == 7) begin
      m_halted = step; m_ph = 0;
    end else begin
      m_ph++;
    end
  endfunction

  function automatic logic [14:0] expect_vec();
    logic rd_e = 0, wr_e = 0, ir_e = 0, acc_e = 0, pc_e = 0, inc_e = 0;
    logic halt_e = 0, de_e = 0, sel_e = 0;
    logic [2:0] ph3;
    ph3 = 3'(m_ph);
    if (m_halted) begin
      halt_e = 1;
    end else if (m_ph < 4) begin
      sel_e = 1; rd_e = (m_ph >= 1); ir_e = (m_ph >= 2);
    end else if (m_ph == 4) begin
      inc_e = 1; halt_e = (opcode == 4'd0);
    end else begin
      rd_e  = is_alu(opcode);
      acc_e = is_alu(opcode) && m_ph == 7;
      pc_e  = (opcode == 4'd7) && m_ph >= 6;
      inc_e = (opcode == 4'd1 && zero && m_ph == 6) || (opcode == 4'd7 && m_ph == 7);
      de_e  = (opcode == 4'd6) && m_ph >= 6;
      wr_e  = (opcode == 4'd6) && m_ph == 7;
    end
    return {rd_e, wr_e, ir_e, acc_e, pc_e, inc_e, halt_e, de_e, sel_e,
            ph3, m_halted, m_berr, m_ill};
  endfunction

  // One clock of stimulus: update the model, drive new inputs, queue expectation.
  task automatic tick(input logic r);
    @(posedge clk);
    model_edge();
    #1;
    if (m_halted || m_ph < 4) begin
      opcode = want_op;
      zero   = want_z;
    end
    if (rnd_mr) mem_rdy = ($urandom_range(0, 3) != 0);
    else mem_rdy = !(!m_halted && m_ph == stall_phase && m_stalls < stall_len);
    go   = want_go;
    step = want_step;
    rst  = r;
    if (!r) model_reset();
    exp_q.push_back(expect_vec());
  endtask

  // Monitor: compare DUT outputs against the queued expectation.
  initial begin
    logic [14:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel,
             phase, halted, bus_err, ill_op};
        vectors++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t {rd,wr,ld_ir,ld_acc,ld_pc,inc_pc,halt,data_e,sel,phase,halted,bus_err,ill_op} actual=%b required=%b",
                   $time, a, e);
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b0; opcode = '0; zero = 1'b0; mem_rdy = 1'b1; go = 1'b0; step = 1'b0;
    want_op = 4'd2; want_z = 0; want_go = 0; want_step = 0;
    rnd_mr = 0; stall_phase = -1; stall_len = 0;
    model_reset();
    tick(1'b0); tick(1'b0);
    // ADD, memory always ready
    want_op = 4'd2; repeat (9) tick(1'b1);
    // STO with three stalled cycles in P7
    want_op = 4'd6; stall_phase = 7; stall_len = 3; repeat (14) tick(1'b1);
    // LDA with memory stuck low in P5 -> timeout, then two more ADDs
    want_op = 4'd5; stall_phase = 5; stall_len = 100; repeat (30) tick(1'b1);
    stall_phase = -1; want_op = 4'd2; repeat (18) tick(1'b1);
    // HLT, wait with go low, then restart
    want_op = 4'd0;
    for (int i = 0; i < 20 && !m_halted; i++) tick(1'b1);
    repeat (10) tick(1'b1);
    want_op = 4'd1; want_z = 1; want_go = 1; tick(1'b1); want_go = 0;
    repeat (9) tick(1'b1);
    want_z = 0; repeat (8) tick(1'b1);
    want_op = 4'd7; repeat (8) tick(1'b1);
    // Illegal opcode in single-step mode, restart, then reset mid-P5
    want_op = 4'hA; want_step = 1;
    for (int i = 0; i < 20 && !m_halted; i++) tick(1'b1);
    want_go = 1; tick(1'b1); want_go = 0; tick(1'b1);
    for (int i = 0; i < 20 && !m_halted; i++) tick(1'b1);
    want_go = 1; tick(1'b1); want_go = 0;
    for (int i = 0; i < 20 && !(m_ph == 5 && !m_halted); i++) tick(1'b1);
    tick(1'b0); tick(1'b0);
    want_step = 0; repeat (4) tick(1'b1);
    // Randomized traffic
    rnd_mr = 1;
    repeat (1500) begin
      want_op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      want_z    = ($urandom_range(0, 1) != 0);
      want_go   = ($urandom_range(0, 3) == 0);
      want_step = ($urandom_range(0, 9) == 0);
      tick(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
